// File: rtl/wb_cfg_bank_pkg.sv
// Shared types for the Wishbone configuration bank.
// Refresh sequencer states and header layout.
package wb_cfg_bank_pkg;

    localparam int HDR_WORDS = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/wb_cfg_bank_cfg_dpram.sv
// Dual-port config RAM: byte-enable read/write port A, read-only port B.
// Power-up image holds the VERSION header followed by the config defaults.
module cfg_dpram
    import wb_cfg_bank_pkg::*;
#(
    parameter int                            DATA_WIDTH   = 16,
    parameter int                            AW           = 8,
    parameter logic [63:0]                   VERSION      = 64'h0,
    parameter int                            NUM_CFG      = 4,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_DEFAULTS = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [AW-1:0]           a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    input  logic [AW-1:0]           b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DATA_WIDTH / 8;

    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        m = '0;
        for (int i = 0; i < HDR_WORDS; i++)
            m[AW'(i)] = DATA_WIDTH'(16'(VERSION >> ((HDR_WORDS - 1 - i) * 16)));
        for (int k = 0; k < NUM_CFG; k++)
            m[AW'(HDR_WORDS + k)] = DATA_WIDTH'(CFG_DEFAULTS >> (k * DATA_WIDTH));
        return m;
    endfunction

    mem_t                  mem = init_mem();
    logic [DATA_WIDTH-1:0] wmask;

    for (genvar g = 0; g < NB; g++) begin : g_mask
        assign wmask[g*8 +: 8] = {8{a_be[g]}};
    end

    always_ff @(posedge clk) begin
        if (|a_be)
            mem[a_addr] <= (mem[a_addr] & ~wmask) | (a_din & wmask);
    end

    always_ff @(posedge clk) begin
        if (rst)
            a_dout <= '0;
        else if (a_en)
            a_dout <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/wb_cfg_bank.sv
// Wishbone configuration bank with read-only VERSION header and
// mirrored config outputs refreshed by a RAM-scanning sequencer.
module wb_cfg_bank
    import wb_cfg_bank_pkg::*;
#(
    parameter int                            DATA_WIDTH     = 16,
    parameter int                            ADDR_WIDTH     = 15,
    parameter int                            MEM_ADDR_WIDTH = 8,
    parameter logic [63:0]                   VERSION        = 64'h0,
    parameter int                            NUM_CFG        = 4,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_DEFAULTS   = '0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wb_stb_i,
    input  logic                          wb_cyc_i,
    input  logic                          wb_we_i,
    input  logic [ADDR_WIDTH-1:0]         wb_adr_i,
    input  logic [DATA_WIDTH-1:0]         wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]       wb_sel_i,
    output logic [DATA_WIDTH-1:0]         wb_dat_o,
    output logic                          wb_ack_o,
    output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_o,
    output logic                          cfg_update_o,
    output logic                          busy_o
);

    localparam int NB = DATA_WIDTH / 8;

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;

    seq_state_e            state_q, state_d;
    idx_t                  k_q, k_d;
    idx_t                  idx, b_addr, ld_idx;
    logic                  req, wr_cfg, pending_q, scan_start, ld_en;
    logic [NB-1:0]         a_be;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  unused_adr;

    assign idx        = wb_adr_i[MEM_ADDR_WIDTH-1:0];
    assign unused_adr = ^wb_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_cfg     = req & wb_we_i & (idx >= idx_t'(HDR_WORDS));
    // Header words never get a byte enable, so they stay read-only
    assign a_be       = wb_sel_i & {NB{wr_cfg & ~resetn}};
    assign b_addr     = idx_t'(HDR_WORDS) + k_q;

    cfg_dpram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .AW          (MEM_ADDR_WIDTH),
        .VERSION     (VERSION),
        .NUM_CFG     (NUM_CFG),
        .CFG_DEFAULTS(CFG_DEFAULTS)
    ) u_ram (
        .clk   (clk),
        .rst   (resetn),
        .a_en  (req),
        .a_be  (a_be),
        .a_addr(idx),
        .a_din (wb_dat_i),
        .a_dout(wb_dat_o),
        .b_addr(b_addr),
        .b_dout(b_dout)
    );

    always_ff @(posedge clk) begin
        if (resetn)
            wb_ack_o <= 1'b0;
        else
            wb_ack_o <= req;
    end

    // A write landing on the SCAN entry edge wins over the clear
    always_ff @(posedge clk) begin
        if (resetn)
            pending_q <= 1'b0;
        else if (wr_cfg)
            pending_q <= 1'b1;
        else if (scan_start)
            pending_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_INIT;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        scan_start = 1'b0;
        unique case (state_q)
            S_INIT: begin
                state_d    = S_SCAN;
                k_d        = '0;
                scan_start = 1'b1;
            end
            S_IDLE: begin
                if (pending_q) begin
                    state_d    = S_SCAN;
                    k_d        = '0;
                    scan_start = 1'b1;
                end
            end
            S_SCAN: begin
                if (k_q == idx_t'(NUM_CFG - 1))
                    state_d = S_FLUSH;
                else
                    k_d = k_q + idx_t'(1);
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Port B data trails its address by one cycle
    assign ld_en  = ((state_q == S_SCAN) && (k_q != '0)) || (state_q == S_FLUSH);
    assign ld_idx = (state_q == S_FLUSH) ? idx_t'(NUM_CFG - 1) : k_q - idx_t'(1);

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        logic [DATA_WIDTH-1:0] word_q;
        always_ff @(posedge clk) begin
            if (resetn)
                word_q <= CFG_DEFAULTS[g*DATA_WIDTH +: DATA_WIDTH];
            else if (ld_en && (ld_idx == idx_t'(g)))
                word_q <= b_dout;
        end
        assign cfg_o[g*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end

    assign cfg_update_o = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_cfg_bank.sv
// Directed bench for wb_cfg_bank with a cycle-level behavioural model.
// Model tracks RAM image, refresh phase and expected WB/cfg outputs.
module tb_wb_cfg_bank;

    localparam int          N    = 4;
    localparam logic [63:0] VER  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DEFS = {16'h0003, 16'h0002, 16'h0001, 16'h00AA};

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [14:0] adr = '0;
    logic [15:0] dat_i = '0;
    logic [1:0]  sel = '0;
    logic [15:0] dat_o;
    logic        ack, upd, busy;
    logic [63:0] cfg;

    int n_vec = 0;
    int n_bad = 0;
    int n_upd = 0;

    wb_cfg_bank #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (15),
        .MEM_ADDR_WIDTH(8),
        .VERSION       (VER),
        .NUM_CFG       (N),
        .CFG_DEFAULTS  (DEFS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wb_stb_i    (stb),
        .wb_cyc_i    (cyc),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_i),
        .wb_sel_i    (sel),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack),
        .cfg_o       (cfg),
        .cfg_update_o(upd),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ph = -2 post-reset, -1 idle, 0..N-1 scan,
    // N flush, N+1 done
    logic [15:0] ram [256];
    logic [15:0] m_cfg [N];
    logic [15:0] snap [N];
    logic [15:0] m_dat = '0;
    logic        m_ack = 1'b0;
    logic        pend = 1'b0;
    int          ph = -2;
    bit          started = 0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) ram[i] = 16'(VER >> ((3 - i) * 16));
        for (int k = 0; k < N; k++) begin
            ram[4+k]   = 16'(DEFS >> (k * 16));
            m_cfg[k]   = 16'(DEFS >> (k * 16));
            snap[k]    = '0;
        end
    end

    always @(posedge clk) begin
        logic r;
        int   a;
        if (resetn) begin
            m_ack = 1'b0;
            m_dat = '0;
            ph    = -2;
            pend  = 1'b0;
            for (int k = 0; k < N; k++) m_cfg[k] = 16'(DEFS >> (k * 16));
        end else begin
            r = cyc && stb && !m_ack;
            a = int'(adr[7:0]);
            if (ph >= 1 && ph <= N) m_cfg[ph-1] = snap[ph-1];
            if (ph >= 0 && ph < N) snap[ph] = ram[4+ph];
            if (ph == -2) begin
                ph = 0; pend = 1'b0;
            end else if (ph == -1) begin
                if (pend) begin ph = 0; pend = 1'b0; end
            end else if (ph == N + 1) begin
                ph = -1;
            end else begin
                ph = ph + 1;
            end
            m_ack = r;
            if (r) begin
                m_dat = ram[a];
                if (we && a >= 4) begin
                    if (sel[0]) ram[a][7:0]  = dat_i[7:0];
                    if (sel[1]) ram[a][15:8] = dat_i[15:8];
                    pend = 1'b1;
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ack", ack, m_ack);
            chk("dat_o", dat_o, m_dat);
            chk("cfg_o", cfg, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
            chk("cfg_update", upd, ph == N + 1);
            chk("busy", busy, ph != -1);
            if (upd) n_upd++;
        end
    end

    task automatic xfer(input logic w, input int a, input logic [15:0] d,
                        input logic [1:0] s, output logic [15:0] rd);
        int n;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = 15'(a); dat_i = d; sel = s;
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n = i;
            if (ack) break;
        end
        chk("ack_latency", n, (ack === 1'b1) ? 1 : 99);
        chk("ack_latency_1", n, 1);
        rd = dat_o;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 60 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        chk("idle_timeout", quiet >= 3, 1'b1);
    endtask

    logic [15:0] ver_exp [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    initial begin
        logic [15:0] rd;
        int c, n0;

        // 1: reset release and post-reset refresh
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        c = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            c++;
            if (upd) break;
        end
        chk("t1_upd_cycle", c + 1, N + 3);
        chk("t1_cfg", cfg, 64'h0003_0002_0001_00AA);
        @(negedge clk);
        chk("t1_busy", busy, 1'b0);

        // 2: version header reads
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, i, 16'h0, 2'b11, rd);
            chk("t2_version", rd, ver_exp[i]);
        end

        // 3: header write is ignored
        n0 = n_upd;
        xfer(1'b1, 1, 16'hBEEF, 2'b11, rd);
        repeat (8) @(negedge clk);
        xfer(1'b0, 1, 16'h0, 2'b11, rd);
        chk("t3_readback", rd, 16'h4567);
        chk("t3_cfg", cfg, 64'h0003_0002_0001_00AA);
        chk("t3_no_update", n_upd - n0, 0);

        // 4: partial byte write into cfg word 1
        n0 = n_upd;
        xfer(1'b1, 5, 16'h1234, 2'b01, rd);
        wait_idle();
        chk("t4_update", n_upd - n0, 1);
        xfer(1'b0, 5, 16'h0, 2'b11, rd);
        chk("t4_readback", rd, 16'h0034);
        chk("t4_cfg1", cfg[31:16], 16'h0034);

        // 5: second write while a refresh is running
        n0 = n_upd;
        xfer(1'b1, 4, 16'h0055, 2'b11, rd);
        @(negedge clk);
        chk("t5_busy", busy, 1'b1);
        xfer(1'b1, 6, 16'h0066, 2'b11, rd);
        wait_idle();
        chk("t5_updates", n_upd - n0, 2);
        chk("t5_cfg0", cfg[15:0], 16'h0055);
        chk("t5_cfg2", cfg[47:32], 16'h0066);

        // 6: reset mid-scan, RAM survives
        xfer(1'b1, 7, 16'h0077, 2'b11, rd);
        repeat (2) @(negedge clk);
        chk("t6_busy", busy, 1'b1);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_cfg_reset", cfg, 64'h0003_0002_0001_00AA);
        chk("t6_ack_reset", ack, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        wait_idle();
        chk("t6_cfg3", cfg[63:48], 16'h0077);
        chk("t6_cfg0", cfg[15:0], 16'h0055);
        xfer(1'b0, 7, 16'h0, 2'b11, rd);
        chk("t6_readback", rd, 16'h0077);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
